ula_exec: RTL and testbench

// - Execute-stage ALU; consumes the 5-bit ALU control code from the ALU-control decoder plus two 32-bit operands.
// - Single-cycle ops (add/sub/logic/compare/branch) return a registered result one cycle after start.
// - MULT/DIV run on an iterative unit (32 steps); busy stalls the pipeline until done.

---
 rtl/ula_pkg.sv | 32 +++
 rtl/ula_if.sv | 21 ++
 rtl/ula_mdu_iter.sv | 96 +++++++++
 rtl/ula_exec.sv | 122 ++++++++++++
 tb/tb_ula_exec.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the execute-stage ALU: widths, control codes, FSM states.
package ula_pkg;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned CODE_W = 5;
    localparam int unsigned CNT_W  = 6;

    localparam logic [CODE_W-1:0] OP_ADD   = 5'd0;
    localparam logic [CODE_W-1:0] OP_SUB   = 5'd1;
    localparam logic [CODE_W-1:0] OP_MULT  = 5'd2;
    localparam logic [CODE_W-1:0] OP_DIV   = 5'd3;
    localparam logic [CODE_W-1:0] OP_AND   = 5'd4;
    localparam logic [CODE_W-1:0] OP_OR    = 5'd5;
    localparam logic [CODE_W-1:0] OP_NAND  = 5'd6;
    localparam logic [CODE_W-1:0] OP_NOR   = 5'd7;
    localparam logic [CODE_W-1:0] OP_BEQ   = 5'd8;
    localparam logic [CODE_W-1:0] OP_BNE   = 5'd9;
    localparam logic [CODE_W-1:0] OP_BGT   = 5'd10;
    localparam logic [CODE_W-1:0] OP_BLT   = 5'd11;
    localparam logic [CODE_W-1:0] OP_SLT   = 5'd12;
    localparam logic [CODE_W-1:0] OP_SLE   = 5'd13;
    localparam logic [CODE_W-1:0] OP_SGE   = 5'd14;
    localparam logic [CODE_W-1:0] OP_PASSB = 5'd31;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

    // Two's complement magnitude; MIN maps to itself, which is correct when read unsigned.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

endpackage

// File: rtl/ula_if.sv
// Request/result bundle between the pipeline and the execute-stage ALU.
interface ula_if;
    import ula_pkg::*;

    logic              start;
    logic              flush;
    logic [CODE_W-1:0] controle;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [WIDTH-1:0]  result;
    logic [WIDTH-1:0]  hi;
    logic              cond;
    logic              zero;
    logic              busy;
    logic              done;

    modport master (output start, flush, controle, a, b,
                    input  result, hi, cond, zero, busy, done);
    modport slave  (input  start, flush, controle, a, b,
                    output result, hi, cond, zero, busy, done);
endinterface

// File: rtl/ula_mdu_iter.sv
// Iterative unsigned-magnitude multiply (shift-add) / restoring divide with final sign fix.
module ula_mdu_iter
    import ula_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last_c,
    output logic [WIDTH-1:0] lo_c,
    output logic [WIDTH-1:0] hi_c
);
    logic [WIDTH-1:0] acc_q, acc_d, mq_q, mq_d, md_q, md_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_q, div_d, negq_q, negq_d, negr_q, negr_d, dz_q, dz_d;

    logic [WIDTH:0]     prod_sum, rem_sh;
    logic               borrow;
    logic [2*WIDTH-1:0] prod, prod_fix;

    always_comb begin
        acc_d  = acc_q;
        mq_d   = mq_q;
        md_d   = md_q;
        cnt_d  = cnt_q;
        div_d  = div_q;
        negq_d = negq_q;
        negr_d = negr_q;
        dz_d   = dz_q;

        prod_sum = {1'b0, acc_q} + {1'b0, md_q};
        rem_sh   = {acc_q, mq_q[WIDTH-1]};
        borrow   = rem_sh < {1'b0, md_q};

        if (load) begin
            acc_d  = '0;
            cnt_d  = '0;
            div_d  = is_div;
            negq_d = a[WIDTH-1] ^ b[WIDTH-1];
            negr_d = a[WIDTH-1];
            dz_d   = is_div && (b == '0);
            mq_d   = is_div ? abs_val(a) : abs_val(b);
            md_d   = is_div ? abs_val(b) : abs_val(a);
        end else if (step) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (div_q) begin
                acc_d = borrow ? rem_sh[WIDTH-1:0] : WIDTH'(rem_sh - {1'b0, md_q});
                mq_d  = {mq_q[WIDTH-2:0], ~borrow};
            end else if (mq_q[0]) begin
                {acc_d, mq_d} = {prod_sum, mq_q[WIDTH-1:1]};
            end else begin
                {acc_d, mq_d} = {1'b0, acc_q, mq_q[WIDTH-1:1]};
            end
        end
    end

    // Signed results: product negated as a whole; quotient/remainder fixed separately.
    always_comb begin
        prod     = {acc_q, mq_q};
        prod_fix = negq_q ? -prod : prod;
        if (div_q) begin
            lo_c = dz_q ? '1 : (negq_q ? -mq_q : mq_q);
            hi_c = negr_q ? -acc_q : acc_q;
        end else begin
            lo_c = prod_fix[WIDTH-1:0];
            hi_c = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    assign last_c = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            mq_q   <= '0;
            md_q   <= '0;
            cnt_q  <= '0;
            div_q  <= 1'b0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            mq_q   <= mq_d;
            md_q   <= md_d;
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            negq_q <= negq_d;
            negr_q <= negr_d;
            dz_q   <= dz_d;
        end
    end
endmodule

// File: rtl/ula_exec.sv
// Execute-stage ALU: single-cycle ops in IDLE, iterative mult/div via CALC/FIX.
module ula_exec
    import ula_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    ula_if.slave bus
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d;
    logic             cond_q, cond_d, done_q, done_d, busy_q, busy_d;

    logic [WIDTH-1:0] alu_res, diff, mdu_lo, mdu_hi;
    logic             alu_cond, eq, lt, mdu_load, mdu_step, mdu_last;

    // Single-cycle datapath.
    always_comb begin
        diff     = bus.a - bus.b;
        eq       = (bus.a == bus.b);
        lt       = $signed(bus.a) < $signed(bus.b);
        alu_res  = '0;
        alu_cond = 1'b0;
        case (bus.controle)
            OP_ADD:   alu_res = bus.a + bus.b;
            OP_SUB:   alu_res = diff;
            OP_AND:   alu_res = bus.a & bus.b;
            OP_OR:    alu_res = bus.a | bus.b;
            OP_NAND:  alu_res = ~(bus.a & bus.b);
            OP_NOR:   alu_res = ~(bus.a | bus.b);
            OP_BEQ:   begin alu_res = diff; alu_cond = eq;         end
            OP_BNE:   begin alu_res = diff; alu_cond = !eq;        end
            OP_BGT:   begin alu_res = diff; alu_cond = !lt && !eq; end
            OP_BLT:   begin alu_res = diff; alu_cond = lt;         end
            OP_SLT:   alu_res = WIDTH'(lt);
            OP_SLE:   alu_res = WIDTH'(lt || eq);
            OP_SGE:   alu_res = WIDTH'(!lt);
            OP_PASSB: alu_res = bus.b;
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        hi_d     = hi_q;
        cond_d   = cond_q;
        done_d   = 1'b0;
        mdu_load = 1'b0;
        mdu_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    if (bus.controle == OP_MULT || bus.controle == OP_DIV) begin
                        mdu_load = 1'b1;
                        state_d  = CALC;
                    end else begin
                        result_d = alu_res;
                        cond_d   = alu_cond;
                        done_d   = 1'b1;
                    end
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    mdu_step = 1'b1;
                    if (mdu_last) state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!bus.flush) begin
                    result_d = mdu_lo;
                    hi_d     = mdu_hi;
                    cond_d   = 1'b0;
                    done_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    ula_mdu_iter u_mdu (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (mdu_load),
        .step   (mdu_step),
        .is_div (bus.controle == OP_DIV),
        .a      (bus.a),
        .b      (bus.b),
        .last_c (mdu_last),
        .lo_c   (mdu_lo),
        .hi_c   (mdu_hi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            hi_q     <= '0;
            cond_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            cond_q   <= cond_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.result = result_q;
    assign bus.hi     = hi_q;
    assign bus.cond   = cond_q;
    assign bus.done   = done_q;
    assign bus.busy   = busy_q;
    assign bus.zero   = (result_q == '0);
endmodule

// File: tb/tb_ula_exec.sv
// Directed self-checking bench for ula_exec.
module tb_ula_exec;
    import ula_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   passed = 0;
    int   total  = 0;
    int   lat, bcnt, seen;

    ula_if bus ();

    ula_exec dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Issue one op at a negedge; return at the negedge where done is seen (or budget expiry).
    task automatic run_op(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                          output int l, output int bc);
        int n;
        @(negedge clk);
        bus.start = 1'b1; bus.controle = code; bus.a = a; bus.b = b;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0; bc = 0;
        while (!bus.done && n < 100) begin
            if (bus.busy) bc++;
            @(negedge clk);
            n++;
        end
        l = n + 1;
    endtask

    task automatic single_op(input string tag, input logic [4:0] code, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] er, input logic ec);
        run_op(code, a, b, lat, bcnt);
        chk({tag, "_lat"}, 64'(lat), 64'd1);
        chk({tag, "_busy"}, 64'(bcnt), 64'd0);
        chk({tag, "_res"}, 64'(bus.result), 64'(er));
        chk({tag, "_cond"}, 64'(bus.cond), 64'(ec));
    endtask

    task automatic md_op(input string tag, input logic [4:0] code, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] elo, input logic [31:0] ehi);
        run_op(code, a, b, lat, bcnt);
        chk({tag, "_lat"}, 64'(lat), 64'd34);
        chk({tag, "_busycyc"}, 64'(bcnt), 64'd33);
        chk({tag, "_res"}, 64'(bus.result), 64'(elo));
        chk({tag, "_hi"}, 64'(bus.hi), 64'(ehi));
        chk({tag, "_cond"}, 64'(bus.cond), 64'd0);
        @(negedge clk);
        chk({tag, "_donepulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.flush = 1'b0; bus.controle = '0; bus.a = '0; bus.b = '0;
        repeat (2) @(negedge clk);
        chk("rst_result", 64'(bus.result), 64'd0);
        chk("rst_hi",     64'(bus.hi),     64'd0);
        chk("rst_cond",   64'(bus.cond),   64'd0);
        chk("rst_zero",   64'(bus.zero),   64'd1);
        chk("rst_busy",   64'(bus.busy),   64'd0);
        chk("rst_done",   64'(bus.done),   64'd0);
        rst_n = 1'b1;

        single_op("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0);
        chk("add_zero", 64'(bus.zero), 64'd0);
        @(negedge clk);
        chk("add_donepulse", 64'(bus.done), 64'd0);

        single_op("blt", OP_BLT, 32'hFFFF_FFFD, 32'h2, 32'hFFFF_FFFB, 1'b1);
        single_op("bgt", OP_BGT, 32'hFFFF_FFFD, 32'h2, 32'hFFFF_FFFB, 1'b0);
        single_op("and", OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0);
        single_op("nand", OP_NAND, 32'h0000_F0F0, 32'h0000_FF00, 32'hFFFF_0FFF, 1'b0);
        single_op("nor", OP_NOR, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0);
        single_op("slt", OP_SLT, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0);
        single_op("sle", OP_SLE, 32'h2, 32'h2, 32'h1, 1'b0);
        single_op("sge", OP_SGE, 32'hFFFF_FFFB, 32'h3, 32'h0, 1'b0);
        single_op("beq", OP_BEQ, 32'h4, 32'h4, 32'h0, 1'b1);
        chk("beq_zero", 64'(bus.zero), 64'd1);
        single_op("bne_eq", OP_BNE, 32'h4, 32'h4, 32'h0, 1'b0);
        single_op("passb", OP_PASSB, 32'h1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        single_op("undef", 5'd20, 32'h5, 32'h5, 32'h0, 1'b0);

        // Back-to-back single-cycle starts.
        @(negedge clk);
        bus.start = 1'b1; bus.controle = OP_SUB; bus.a = 32'h5; bus.b = 32'h5;
        @(negedge clk);
        chk("b2b_sub_done", 64'(bus.done), 64'd1);
        chk("b2b_sub_zero", 64'(bus.zero), 64'd1);
        bus.controle = OP_OR; bus.a = 32'hF0; bus.b = 32'h0F;
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_or_done", 64'(bus.done), 64'd1);
        chk("b2b_or_res", 64'(bus.result), 64'hFF);

        single_op("bne", OP_BNE, 32'h9, 32'h4, 32'h5, 1'b1);

        md_op("mult_neg", OP_MULT, 32'hFFFF_FFFA, 32'h7, 32'hFFFF_FFD6, 32'hFFFF_FFFF);
        md_op("mult_hi", OP_MULT, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h1);
        chk("mult_hi_zero", 64'(bus.zero), 64'd1);
        md_op("mult_m1m1", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'h0);
        md_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        md_op("div_minm1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
        md_op("div_by0", OP_DIV, 32'h5, 32'h0, 32'hFFFF_FFFF, 32'h5);

        // Start during busy is ignored; flush mid-CALC aborts without done.
        @(negedge clk);
        bus.start = 1'b1; bus.controle = OP_DIV; bus.a = 32'd100; bus.b = 32'd7;
        @(negedge clk);
        bus.controle = OP_ADD; bus.a = 32'h1; bus.b = 32'h1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("busy_ign_done", 64'(bus.done), 64'd0);
        end
        chk("busy_ign_busy", 64'(bus.busy), 64'd1);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_busy", 64'(bus.busy), 64'd0);
        chk("flush_done", 64'(bus.done), 64'd0);
        chk("flush_res", 64'(bus.result), 64'hFFFF_FFFF);
        chk("flush_hi", 64'(bus.hi), 64'h5);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen++;
        end
        chk("flush_nodone", 64'(seen), 64'd0);

        // Flush wins over start in IDLE.
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.controle = OP_ADD; bus.a = 32'h1; bus.b = 32'h1;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        chk("flush_start_done", 64'(bus.done), 64'd0);
        chk("flush_start_res", 64'(bus.result), 64'hFFFF_FFFF);

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        bus.start = 1'b1; bus.controle = OP_MULT; bus.a = 32'h3; bus.b = 32'h5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", 64'(bus.busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy",   64'(bus.busy),   64'd0);
        chk("arst_done",   64'(bus.done),   64'd0);
        chk("arst_result", 64'(bus.result), 64'd0);
        chk("arst_hi",     64'(bus.hi),     64'd0);
        chk("arst_zero",   64'(bus.zero),   64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_busy", 64'(bus.busy), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
